avalon_pkt_truncator: RTL
=========================

// Module: avalon_pkt_truncator
// PURPOSE
// - Downstream stage of the Avalon-ST framing enforcer; consumes its cleaned sop/eop stream.
// - Enforces a maximum packet length of MAX_LEN_WORDS beats.
// - Packets within the limit pass unchanged.
// - Longer packets are cut:
//   - eop is forced on beat MAX_LEN_WORDS.
//   - The remaining beats are discarded up to and including the input eop.
// - Output is registered: one pipeline stage with full-throughput ready/valid.
// PARAMETERS
// - MAX_LEN_WORDS  256                          max beats per packet, legal range >= 1
// - CNT_W          $clog2(MAX_LEN_WORDS+1)      beat counter width, derived, not overridden
// PORTS
// - clk            in   1     single clock, all logic on posedge
// - rst            in   1     reset: synchronous, active-high
// - untrusted_msg  avalon_st_if.slave    input stream (valid, rdy, sop, eop, data, empty)
// - trusted_msg    avalon_st_if.master   output stream, same data/empty widths as input
// - pkt_truncated  out  1     1-cycle pulse, see BEHAVIOUR
// - framing_err    out  1     1-cycle pulse: accepted beat without sop while in IDLE
// BEHAVIOUR
// - Reset (rst=1 at posedge) clears:
//   - state to IDLE and the beat counter to 0.
//   - trusted_msg.valid/sop/eop, data, empty to 0.
//   - pkt_truncated and framing_err to 0.
// - Handshake:
//   - in_acc = untrusted_msg.valid & untrusted_msg.rdy.
//   - Outside DROP: untrusted_msg.rdy = ~trusted_msg.valid | trusted_msg.rdy (no bubble when drained).
//   - In DROP: untrusted_msg.rdy = 1.
//   - The output register loads on in_acc & forward, and holds while trusted_msg.valid & ~trusted_msg.rdy.
//   - trusted_msg.valid clears when the register is consumed and no new beat loads.
// - Latency: an accepted, forwarded beat appears on trusted_msg exactly 1 cycle after acceptance.
// - FSM:
//   - IDLE:
//     - in_acc & sop: forward, cnt<=1.
//       - If eop: stay IDLE.
//       - Else if MAX_LEN_WORDS==1: truncate.
//       - Else: go IN_PKT.
//     - in_acc & ~sop: discard, pulse framing_err, stay IDLE.
//   - IN_PKT: each in_acc forwards the beat and increments cnt. Output sop is forced 0.
//     - eop: go IDLE, cnt<=0.
//     - cnt+1==MAX_LEN_WORDS & ~eop: truncate.
//   - Truncate: the beat is forwarded with eop=1 and empty=0. pkt_truncated pulses; go DROP.
//   - DROP: in_acc beats are discarded.
//     - sop is also discarded; upstream guarantees none arrives mid-packet.
//     - On in_acc & eop: go IDLE, cnt<=0.
// - A packet of exactly MAX_LEN_WORDS beats is NOT truncated: its own eop wins, pkt_truncated stays 0.
// - empty: passed through only on forwarded eop beats; 0 on all other beats.
// - pkt_truncated and framing_err are registered, asserted in the cycle the related beat loads or is discarded.
// - The counter never exceeds MAX_LEN_WORDS; no wrap is possible.
// - Reset mid-packet:
//   - Any beat held in the output register is lost.
//   - The next accepted beat is evaluated from IDLE.
// CONFIGURATION
// - Macro AVALON_TRUNC_STATS_EN.
// - When defined, adds outputs stat_pkts, stat_trunc, stat_drop_words (32 bit each):
//   - Counts of forwarded sop, truncations, and discarded beats (DROP and framing_err).
//   - All saturating at 32'hFFFF_FFFF; cleared by rst.
// - When not defined: the ports and counters are absent; all other behaviour is identical.
// TESTING (MAX_LEN_WORDS=4, trusted_msg.rdy=1 unless stated)
// - 3-beat packet (sop b0, eop b2, empty=2):
//   - Output is identical one cycle later, empty=2 on b2, no pulses.
// - 4-beat packet:
//   - Passes unmodified, eop on beat 4, pkt_truncated=0.
// - 7-beat packet (empty=3):
//   - 4 beats out, beat 4 with eop=1 and empty=0; pkt_truncated pulses once.
//   - Beats 5-7 dropped with untrusted_msg.rdy=1; next packet starts cleanly.
// - Beat without sop in IDLE (data=0xAB):
//   - trusted_msg.valid stays 0, framing_err=1 for one cycle.
// - Backpressure: trusted_msg.rdy=0 for 3 cycles during a 3-beat packet:
//   - untrusted_msg.rdy=0 while the register is full.
//   - No beat is lost or duplicated; order preserved.
// - rst=1 for one cycle in mid-packet, then a new 2-beat packet:
//   - Outputs are 0 after reset; the new packet is forwarded intact.
//   - With AVALON_TRUNC_STATS_EN: counters read 0 then stat_pkts=1.

Source files
------------

// File: rtl/avalon_st_if.sv
// Avalon-ST streaming bundle: valid/rdy handshake with sop/eop framing, data and empty.
interface avalon_st_if #(
  parameter int DATA_W  = 32,
  parameter int EMPTY_W = 2
) ();
  logic               valid;
  logic               rdy;
  logic               sop;
  logic               eop;
  logic [DATA_W-1:0]  data;
  logic [EMPTY_W-1:0] empty;

  modport master (output valid, sop, eop, data, empty, input rdy);
  modport slave  (input valid, sop, eop, data, empty, output rdy);
endinterface

// File: rtl/avalon_pkt_truncator.sv
// Caps Avalon-ST packets at MAX_LEN_WORDS beats: long packets get a forced eop, their tail is dropped.
// Optional statistics counters are enabled with the macro AVALON_TRUNC_STATS_EN.
module avalon_pkt_truncator #(
  parameter int MAX_LEN_WORDS = 256,
  parameter int DATA_W        = 32,
  parameter int EMPTY_W       = 2
) (
  input  logic        clk,
  input  logic        rst,
  avalon_st_if.slave  untrusted_msg,
  avalon_st_if.master trusted_msg,
  output logic        pkt_truncated,
  output logic        framing_err
`ifdef AVALON_TRUNC_STATS_EN
  ,
  output logic [31:0] stat_pkts,
  output logic [31:0] stat_trunc,
  output logic [31:0] stat_drop_words
`endif
);

  localparam int             CNT_W    = $clog2(MAX_LEN_WORDS + 1);
  localparam logic [CNT_W-1:0] LIMIT  = CNT_W'(MAX_LEN_WORDS);
  localparam logic           ONE_BEAT = (MAX_LEN_WORDS == 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_IN_PKT = 2'd1;
  localparam logic [1:0] S_DROP   = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] cnt_inc;

  logic is_idle;
  logic is_pkt;
  logic is_drop;
  logic in_rdy;
  logic in_acc;
  logic fwd;
  logic at_limit;
  logic trunc;
  logic ferr;
  logic drop_beat;

  logic               vld_p1;
  logic               sop_p1;
  logic               eop_p1;
  logic [DATA_W-1:0]  data_p1;
  logic [EMPTY_W-1:0] empty_p1;

  // ---- stage p0: input decode and packet state ----
  assign is_idle = (state == S_IDLE);
  assign is_pkt  = (state == S_IN_PKT);
  assign is_drop = (state == S_DROP);

  // The tail of a cut packet is swallowed regardless of downstream backpressure.
  assign in_rdy  = is_drop ? 1'b1 : (~vld_p1 | trusted_msg.rdy);
  assign in_acc  = untrusted_msg.valid & in_rdy;
  assign untrusted_msg.rdy = in_rdy;

  assign cnt_inc   = cnt + CNT_W'(1);
  assign fwd       = in_acc & ((is_idle & untrusted_msg.sop) | is_pkt);
  assign at_limit  = is_idle ? ONE_BEAT : (cnt_inc == LIMIT);
  assign trunc     = fwd & ~untrusted_msg.eop & at_limit;
  assign ferr      = in_acc & is_idle & ~untrusted_msg.sop;
  assign drop_beat = in_acc & is_drop;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (fwd) begin
          cnt_nxt = CNT_W'(1);
          if (trunc)
            state_nxt = S_DROP;
          else if (!untrusted_msg.eop)
            state_nxt = S_IN_PKT;
        end
      end
      S_IN_PKT: begin
        if (fwd) begin
          if (untrusted_msg.eop) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt_inc;
            if (trunc)
              state_nxt = S_DROP;
          end
        end
      end
      S_DROP: begin
        if (in_acc && untrusted_msg.eop) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // ---- stage p1: output register and event pulses ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      sop_p1   <= 1'b0;
      eop_p1   <= 1'b0;
      data_p1  <= '0;
      empty_p1 <= '0;
    end else if (fwd) begin
      vld_p1   <= 1'b1;
      sop_p1   <= is_idle;
      eop_p1   <= untrusted_msg.eop | trunc;
      data_p1  <= untrusted_msg.data;
      empty_p1 <= untrusted_msg.eop ? untrusted_msg.empty : '0;
    end else if (trusted_msg.rdy) begin
      vld_p1 <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_truncated <= 1'b0;
      framing_err   <= 1'b0;
    end else begin
      pkt_truncated <= trunc;
      framing_err   <= ferr;
    end
  end

  assign trusted_msg.valid = vld_p1;
  assign trusted_msg.sop   = sop_p1;
  assign trusted_msg.eop   = eop_p1;
  assign trusted_msg.data  = data_p1;
  assign trusted_msg.empty = empty_p1;

`ifdef AVALON_TRUNC_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    if (en && (v != 32'hFFFF_FFFF))
      return v + 32'd1;
    return v;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_pkts       <= '0;
      stat_trunc      <= '0;
      stat_drop_words <= '0;
    end else begin
      stat_pkts       <= sat_inc(stat_pkts, fwd & is_idle);
      stat_trunc      <= sat_inc(stat_trunc, trunc);
      stat_drop_words <= sat_inc(stat_drop_words, drop_beat | ferr);
    end
  end
`else
  logic unused_drop;
  assign unused_drop = drop_beat;
`endif

endmodule
